// File: rtl/flit_sink_monitor.sv
// flit_sink_monitor
//   Receiving end of a router flit link. Consumes one flit per cycle with no
//   backpressure, checks HEAD -> DATA* -> TAIL framing per packet, reports the
//   length and VC of each completed packet, and keeps saturating counters of
//   accepted flits and of link bit toggles (switching activity).
//   Optional feature macro: TOGGLE_CNT_EN builds the prev_data register and the
//   toggle counter; when undefined, toggle_cnt is tied to 0.
module flit_sink_monitor #(
    parameter int               DATAW  = 66,
    parameter int               TYPEW  = 2,
    parameter int               VCHW   = 1,
    parameter int               LENW   = 8,
    parameter int               CNTW   = 32,
    parameter logic [TYPEW-1:0] T_NONE = 2'b00,
    parameter logic [TYPEW-1:0] T_HEAD = 2'b01,
    parameter logic [TYPEW-1:0] T_TAIL = 2'b10,
    parameter logic [TYPEW-1:0] T_DATA = 2'b11
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    input  logic [VCHW-1:0]  ivch,
    input  logic             clr,
    output logic             pkt_done,
    output logic [LENW-1:0]  pkt_len,
    output logic [VCHW-1:0]  pkt_vch,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNTW-1:0]  flit_cnt,
    output logic [CNTW-1:0]  toggle_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        E_NONE   = 2'b00,
        E_ORPHAN = 2'b01,
        E_HEAD   = 2'b10,
        E_VCH    = 2'b11
    } err_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LENW-1:0]    r_len;
    logic [LENW-1:0]    w_len_nxt;
    logic [LENW-1:0]    w_len_inc;
    logic [VCHW-1:0]    r_vch;
    logic [VCHW-1:0]    w_vch_nxt;
    logic               w_tail;
    err_t               w_err_new;

    logic               r_pkt_done;
    logic [LENW-1:0]    r_pkt_len;
    logic [VCHW-1:0]    r_pkt_vch;
    logic               r_err;
    err_t               r_err_code;
    logic [CNTW-1:0]    r_flit_cnt;

    logic [TYPEW-1:0]   w_type;
    logic               w_flit_v;

    assign w_type    = idata[DATAW-1 -: TYPEW];
    assign w_flit_v  = ivalid && (w_type != T_NONE);
    assign w_len_inc = (r_len == '1) ? r_len : r_len + LENW'(1);

    // FSM state, running packet length and latched VC
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_vch   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_vch   <= w_vch_nxt;
        end
    end

    // Next-state, length and framing-error decode; clr overrides everything
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_vch_nxt   = r_vch;
        w_tail      = 1'b0;
        w_err_new   = E_NONE;
        unique case (r_state)
            S_IDLE: begin
                if (w_flit_v) begin
                    if (w_type == T_HEAD) begin
                        w_state_nxt = S_BODY;
                        w_len_nxt   = LENW'(1);
                        w_vch_nxt   = ivch;
                    end else begin
                        w_err_new   = E_ORPHAN;
                    end
                end
            end
            S_BODY: begin
                if (w_flit_v) begin
                    if (w_type == T_HEAD) begin
                        // Restart on the new HEAD; the broken packet is never reported.
                        w_err_new = E_HEAD;
                        w_len_nxt = LENW'(1);
                        w_vch_nxt = ivch;
                    end else begin
                        if (ivch != r_vch) begin
                            w_err_new = E_VCH;
                        end
                        if (w_type == T_TAIL) begin
                            w_tail      = 1'b1;
                            w_state_nxt = S_IDLE;
                            w_len_nxt   = '0;
                        end else begin
                            w_len_nxt   = w_len_inc;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (clr) begin
            w_state_nxt = S_IDLE;
            w_len_nxt   = '0;
            w_tail      = 1'b0;
            w_err_new   = E_NONE;
        end
    end

    // Packet completion report: one-cycle pulse, length/VC held until the next one
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_pkt_done <= 1'b0;
            r_pkt_len  <= '0;
            r_pkt_vch  <= '0;
        end else begin
            r_pkt_done <= w_tail;
            if (w_tail) begin
                r_pkt_len <= w_len_inc;
                r_pkt_vch <= r_vch;
            end
        end
    end

    // Sticky framing error: only the first error code is kept
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_err      <= 1'b0;
            r_err_code <= E_NONE;
        end else if (clr) begin
            r_err      <= 1'b0;
            r_err_code <= E_NONE;
        end else if (!r_err && (w_err_new != E_NONE)) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_new;
        end
    end

    // Saturating count of valid non-idle flits, in any FSM state
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_flit_cnt <= '0;
        end else if (clr) begin
            r_flit_cnt <= '0;
        end else if (w_flit_v && (r_flit_cnt != '1)) begin
            r_flit_cnt <= r_flit_cnt + CNTW'(1);
        end
    end

`ifdef TOGGLE_CNT_EN
    localparam int PCW = $clog2(DATAW + 1);

    logic [DATAW-1:0] r_prev_data;
    logic [CNTW-1:0]  r_toggle_cnt;
    logic [DATAW-1:0] w_diff;
    logic [PCW-1:0]   w_popcnt;
    logic [CNTW:0]    w_tog_sum;

    assign w_diff    = idata ^ r_prev_data;
    assign w_tog_sum = {1'b0, r_toggle_cnt} + (CNTW + 1)'(w_popcnt);

    // Hamming distance between this sample and the previous one
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < DATAW; i++) begin
            w_popcnt = w_popcnt + PCW'(w_diff[i]);
        end
    end

    // Previous-sample register and saturating toggle accumulator; prev_data loads even under clr
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_prev_data  <= '0;
            r_toggle_cnt <= '0;
        end else begin
            r_prev_data <= idata;
            if (clr) begin
                r_toggle_cnt <= '0;
            end else if (w_tog_sum[CNTW]) begin
                r_toggle_cnt <= '1;
            end else begin
                r_toggle_cnt <= w_tog_sum[CNTW-1:0];
            end
        end
    end

    assign toggle_cnt = r_toggle_cnt;
`else
    // Payload bits only matter for toggle counting, which is not built here.
    logic w_unused_payload;
    assign w_unused_payload = ^idata[DATAW-TYPEW-1:0];
    assign toggle_cnt       = '0;
`endif

    assign pkt_done = r_pkt_done;
    assign pkt_len  = r_pkt_len;
    assign pkt_vch  = r_pkt_vch;
    assign busy     = (r_state == S_BODY);
    assign err      = r_err;
    assign err_code = r_err_code;
    assign flit_cnt = r_flit_cnt;

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Testbench for flit_sink_monitor: directed flit sequences; completed packets
// are predicted into a queue and checked by an independent monitor process.
module tb_flit_sink_monitor;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_DATA = 2'b11;

    logic        clk = 1'b0;
    logic        rst_;
    logic [65:0] idata;
    logic        ivalid;
    logic        ivch;
    logic        clr;
    logic        pkt_done;
    logic [7:0]  pkt_len;
    logic        pkt_vch;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] flit_cnt;
    logic [31:0] toggle_cnt;

    typedef struct packed {
        logic [7:0] len;
        logic       vch;
    } exp_t;

    exp_t q_exp[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_done  = 0;

    flit_sink_monitor dut (
        .clk        (clk),
        .rst_       (rst_),
        .idata      (idata),
        .ivalid     (ivalid),
        .ivch       (ivch),
        .clr        (clr),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .pkt_vch    (pkt_vch),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code),
        .flit_cnt   (flit_cnt),
        .toggle_cnt (toggle_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one input cycle; returns 1 time unit after the sampling edge.
    task automatic drive(input logic v, input logic [1:0] t, input logic vc, input logic [63:0] pay);
        ivalid = v;
        idata  = {t, pay};
        ivch   = vc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, T_NONE, 1'b0, 64'h0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        drive(1'b0, T_NONE, 1'b0, 64'h0);
        clr = 1'b0;
    endtask

    task automatic send_pkt(input logic vc, input int ndata);
        drive(1'b1, T_HEAD, vc, 64'hA5A5_0000_0000_0001);
        for (int i = 0; i < ndata; i++) drive(1'b1, T_DATA, vc, 64'(i * 32'h0101_0101));
        q_exp.push_back('{len: 8'(ndata + 2), vch: vc});
        drive(1'b1, T_TAIL, vc, 64'h5A5A_FFFF_0000_0002);
    endtask

    // Monitor: every pkt_done pulse must match the oldest predicted packet
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ && pkt_done) begin
                n_done++;
                if (q_exp.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_pkt_done: got pkt_done=1 len=%0d expected no packet (t=%0t)", pkt_len, $time);
                end else begin
                    e = q_exp.pop_front();
                    check("pkt_len", 64'(pkt_len), 64'(e.len));
                    check("pkt_vch", 64'(pkt_vch), 64'(e.vch));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int done_base;
        rst_ = 1'b0; clr = 1'b0; ivalid = 1'b0; ivch = 1'b0; idata = '0;

        // 1. reset, then idle
        repeat (3) @(posedge clk);
        #1 rst_ = 1'b1;
        idle(3);
        check("rst_pkt_done",   64'(pkt_done),   64'd0);
        check("rst_pkt_len",    64'(pkt_len),    64'd0);
        check("rst_pkt_vch",    64'(pkt_vch),    64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_err",        64'(err),        64'd0);
        check("rst_err_code",   64'(err_code),   64'd0);
        check("rst_flit_cnt",   64'(flit_cnt),   64'd0);
        check("rst_toggle_cnt", 64'(toggle_cnt), 64'd0);

        // 2. single 22-flit packet on vch 1
        send_pkt(1'b1, 20);
        check("t2_done_latency", 64'(pkt_done), 64'd1);
        check("t2_busy_after",   64'(busy),     64'd0);
        check("t2_flit_cnt",     64'(flit_cnt), 64'd22);
        check("t2_err",          64'(err),      64'd0);
        idle(1);
        check("t2_done_pulse",   64'(pkt_done), 64'd0);

        // 3. ten packets with 7 idle cycles between
        do_clr();
        check("clr_flit_cnt", 64'(flit_cnt), 64'd0);
        done_base = n_done;
        for (int p = 0; p < 10; p++) begin
            send_pkt(1'b1, 20);
            idle(1);
            check("t3_busy_gap", 64'(busy), 64'd0);
            idle(6);
        end
        check("t3_pkt_count", 64'(n_done - done_base), 64'd10);
        check("t3_flit_cnt",  64'(flit_cnt),          64'd220);
        check("t3_err",       64'(err),               64'd0);

        // 4. orphan DATA, clr, then HEAD inside packet
        do_clr();
        drive(1'b1, T_DATA, 1'b0, 64'h1);
        check("t4_orphan_err",  64'(err),      64'd1);
        check("t4_orphan_code", 64'(err_code), 64'd1);
        check("t4_orphan_busy", 64'(busy),     64'd0);
        do_clr();
        check("t4_clr_err",  64'(err),      64'd0);
        check("t4_clr_code", 64'(err_code), 64'd0);
        drive(1'b1, T_HEAD, 1'b0, 64'h10);
        drive(1'b1, T_DATA, 1'b0, 64'h11);
        drive(1'b1, T_HEAD, 1'b0, 64'h12);
        q_exp.push_back('{len: 8'd2, vch: 1'b0});
        drive(1'b1, T_TAIL, 1'b0, 64'h13);
        check("t4_head_code", 64'(err_code), 64'd2);
        idle(2);
        // a later VC change must not overwrite the first error code
        drive(1'b1, T_HEAD, 1'b0, 64'h20);
        drive(1'b1, T_DATA, 1'b1, 64'h21);
        q_exp.push_back('{len: 8'd3, vch: 1'b0});
        drive(1'b1, T_TAIL, 1'b0, 64'h22);
        check("t4_sticky_code", 64'(err_code), 64'd2);
        idle(2);

        // VC change inside a packet as the first error
        do_clr();
        drive(1'b1, T_HEAD, 1'b1, 64'h30);
        drive(1'b1, T_DATA, 1'b0, 64'h31);
        check("vch_err_code", 64'(err_code), 64'd3);
        q_exp.push_back('{len: 8'd3, vch: 1'b1});
        drive(1'b1, T_TAIL, 1'b1, 64'h32);
        idle(2);

        // bubbles and NONE flits inside a packet do not change len
        do_clr();
        drive(1'b1, T_HEAD, 1'b1, 64'h40);
        drive(1'b0, T_DATA, 1'b1, 64'h41);
        drive(1'b1, T_NONE, 1'b1, 64'h42);
        drive(1'b1, T_DATA, 1'b1, 64'h43);
        idle(1);
        check("bubble_busy", 64'(busy), 64'd1);
        q_exp.push_back('{len: 8'd3, vch: 1'b1});
        drive(1'b1, T_TAIL, 1'b1, 64'h44);
        check("bubble_flit_cnt", 64'(flit_cnt), 64'd3);
        check("bubble_err",      64'(err),      64'd0);
        // back-to-back: HEAD right after TAIL
        drive(1'b1, T_HEAD, 1'b0, 64'h50);
        q_exp.push_back('{len: 8'd2, vch: 1'b0});
        drive(1'b1, T_TAIL, 1'b0, 64'h51);
        check("b2b_err", 64'(err), 64'd0);
        idle(2);

        // 5. toggle counting (clr cycle loads prev_data with 0)
        do_clr();
        drive(1'b0, T_DATA, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, T_NONE, 1'b0, 64'h0);
        drive(1'b0, T_NONE, 1'b0, 64'h0000_3FFF_FFFF_FFFF);
`ifdef TOGGLE_CNT_EN
        check("t5_toggle_cnt", 64'(toggle_cnt), 64'd178);
`else
        check("t5_toggle_cnt", 64'(toggle_cnt), 64'd0);
`endif
        check("t5_flit_cnt", 64'(flit_cnt), 64'd0);
        idle(1);

        // 6. reset mid-packet discards it
        do_clr();
        drive(1'b1, T_HEAD, 1'b1, 64'h60);
        for (int i = 0; i < 5; i++) drive(1'b1, T_DATA, 1'b1, 64'(i));
        check("t6_busy_pre", 64'(busy), 64'd1);
        rst_ = 1'b0;
        @(posedge clk);
        #1 rst_ = 1'b1;
        check("t6_busy_rst",     64'(busy),     64'd0);
        check("t6_flit_cnt_rst", 64'(flit_cnt), 64'd0);
        drive(1'b1, T_TAIL, 1'b1, 64'h61);
        check("t6_no_done",  64'(pkt_done), 64'd0);
        check("t6_err",      64'(err),      64'd1);
        check("t6_err_code", 64'(err_code), 64'd1);
        idle(3);

        check("scoreboard_empty", 64'(q_exp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
